// File: rtl/sobel_edge.sv
// sobel_edge: 3x3 Sobel edge detector for the 640-wide VGA pixel pipeline.
// Consumes the smoothed grayscale stream and produces a saturated gradient
// magnitude, a thresholded edge flag and a matching valid strobe (3-cycle latency).
// Build option: define SOBEL_BINARY_EN to drive sobel_out as a binary edge map
// (255 on edge, 0 otherwise) instead of the saturated magnitude.
module sobel_edge #(
  parameter int unsigned IMG_WIDTH = 640,
  parameter int unsigned MAG_W     = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] gray_in,
  input  logic [9:0] x_pixel,
  input  logic [9:0] y_pixel,
  input  logic       disp_enable,
  input  logic [7:0] threshold,
  output logic [7:0] sobel_out,
  output logic       edge_out,
  output logic       out_valid
);

  localparam logic [9:0] LastX = 10'(IMG_WIDTH - 1);

  // Line buffers: lb1 holds row y-1, lb2 holds row y-2. Never reset so they map to BRAM.
  logic [7:0] lb1 [IMG_WIDTH];
  logic [7:0] lb2 [IMG_WIDTH];
  logic [7:0] lb1_rd, lb2_rd;

  // 3x3 window; pRC with R=1 top (y-2) .. 3 bottom (y), C=1 column x-2 .. 3 column x.
  logic [7:0] p11, p12, p13, p21, p22, p23, p31, p32, p33;

  logic [1:0] rows_seen;
  logic       valid_in, v_s1, v_s2;

  logic [9:0]        gx_pos, gx_neg, gy_pos, gy_neg;
  logic signed [10:0] gx_d, gy_d, gx, gy;
  logic [10:0]       abs_gx, abs_gy;
  logic [MAG_W-1:0]  mag;
  logic              is_edge;
  logic [7:0]        sob_val;

  assign lb1_rd = lb1[x_pixel];
  assign lb2_rd = lb2[x_pixel];

  // Line buffer update on every accepted pixel: old row y-1 moves down to row y-2.
  always_ff @(posedge clk) begin
    if (disp_enable) begin
      lb2[x_pixel] <= lb1_rd;
      lb1[x_pixel] <= gray_in;
    end
  end

  // Stage 1: window shifts left and takes the new column only on accepted pixels.
  always_ff @(posedge clk) begin
    if (rst) begin
      p11 <= '0; p12 <= '0; p13 <= '0;
      p21 <= '0; p22 <= '0; p23 <= '0;
      p31 <= '0; p32 <= '0; p33 <= '0;
    end else if (disp_enable) begin
      p11 <= p12; p12 <= p13; p13 <= lb2_rd;
      p21 <= p22; p22 <= p23; p23 <= lb1_rd;
      p31 <= p32; p32 <= p33; p33 <= gray_in;
    end
  end

  // Count completed lines since reset so stale buffer rows are never reported as valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      rows_seen <= 2'd0;
    end else if (disp_enable && (x_pixel == LastX) && (rows_seen != 2'd2)) begin
      rows_seen <= rows_seen + 2'd1;
    end
  end

  // Wrap-around columns (x<2), the first two rows and post-reset rows are masked here.
  assign valid_in = disp_enable && (x_pixel >= 10'd2) && (y_pixel >= 10'd2) &&
                    (rows_seen == 2'd2);

  // Valid pipeline stages aligned with the window and gradient registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_s1 <= 1'b0;
      v_s2 <= 1'b0;
    end else begin
      v_s1 <= valid_in;
      v_s2 <= v_s1;
    end
  end

  // Positive and negative halves stay below 1021, so the 11-bit difference cannot overflow.
  assign gx_pos = {2'b0, p13} + {1'b0, p23, 1'b0} + {2'b0, p33};
  assign gx_neg = {2'b0, p11} + {1'b0, p21, 1'b0} + {2'b0, p31};
  assign gy_pos = {2'b0, p31} + {1'b0, p32, 1'b0} + {2'b0, p33};
  assign gy_neg = {2'b0, p11} + {1'b0, p12, 1'b0} + {2'b0, p13};
  assign gx_d   = $signed({1'b0, gx_pos}) - $signed({1'b0, gx_neg});
  assign gy_d   = $signed({1'b0, gy_pos}) - $signed({1'b0, gy_neg});

  // Stage 2: register signed gradients every clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      gx <= '0;
      gy <= '0;
    end else begin
      gx <= gx_d;
      gy <= gy_d;
    end
  end

  assign abs_gx  = gx[10] ? 11'(-gx) : 11'(gx);
  assign abs_gy  = gy[10] ? 11'(-gy) : 11'(gy);
  assign mag     = MAG_W'(abs_gx) + MAG_W'(abs_gy);
  assign is_edge = (mag >= MAG_W'(threshold));

`ifdef SOBEL_BINARY_EN
  assign sob_val = is_edge ? 8'd255 : 8'd0;
`else
  assign sob_val = (mag > MAG_W'(255)) ? 8'd255 : mag[7:0];
`endif

  // Stage 3: registered, valid-qualified outputs; invalid cycles read as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      edge_out  <= 1'b0;
      sobel_out <= 8'd0;
    end else begin
      out_valid <= v_s2;
      edge_out  <= v_s2 && is_edge;
      sobel_out <= v_s2 ? sob_val : 8'd0;
    end
  end

endmodule

// File: tb/tb_sobel_edge.sv
// tb_sobel_edge: directed image streams with a table of hand-computed per-pixel results.
// Results are filed under the coordinates of the pixel whose acceptance produced them.
module tb_sobel_edge;

`ifdef SOBEL_BINARY_EN
  localparam bit Bin = 1'b1;
`else
  localparam bit Bin = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] gray_in;
  logic [9:0] x_pixel, y_pixel;
  logic       disp_enable;
  logic [7:0] threshold;
  logic [7:0] sobel_out;
  logic       edge_out, out_valid;

  always #5 clk = ~clk;

  sobel_edge #(.IMG_WIDTH(640), .MAG_W(12)) dut (
    .clk        (clk),
    .rst        (rst),
    .gray_in    (gray_in),
    .x_pixel    (x_pixel),
    .y_pixel    (y_pixel),
    .disp_enable(disp_enable),
    .threshold  (threshold),
    .sobel_out  (sobel_out),
    .edge_out   (edge_out),
    .out_valid  (out_valid)
  );

  typedef struct {
    int test;
    int x;
    int y;
    bit v;
    int mag;
    bit e;
  } vec_t;

  vec_t tbl[$];

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] cap_s [16][640];
  bit         cap_e [16][640];
  bit         cap_v [16][640];
  int         hx [2];
  int         hy [2];
  bit         he [2];
  int         gap_valid_seen = 0;

  // Image generators: 0 flat, 1 vertical step at x=320, 2 horizontal step at y=10.
  function automatic logic [7:0] pix(input int img, input int x, input int y);
    case (img)
      0:       return 8'd100;
      1:       return (x < 320) ? 8'd0 : 8'd200;
      default: return (y < 10) ? 8'd0 : 8'd50;
    endcase
  endfunction

  function automatic void add(input int t, input int x, input int y, input bit v,
                              input int mag, input bit e);
    vec_t r;
    r.test = t; r.x = x; r.y = y; r.v = v; r.mag = mag; r.e = e;
    tbl.push_back(r);
  endfunction

  // One clock of stimulus; the output seen afterwards belongs to the push two calls back.
  task automatic push(input bit en, input int x, input int y, input int img, input bit r);
    rst         = r;
    disp_enable = en;
    x_pixel     = 10'(x);
    y_pixel     = 10'(y);
    gray_in     = pix(img, x, y);
    @(posedge clk);
    #1;
    if (he[1]) begin
      cap_s[hy[1] % 16][hx[1]] = sobel_out;
      cap_e[hy[1] % 16][hx[1]] = edge_out;
      cap_v[hy[1] % 16][hx[1]] = out_valid;
    end else if (out_valid) begin
      gap_valid_seen++;
    end
    hx[1] = hx[0]; hy[1] = hy[0]; he[1] = he[0];
    hx[0] = x;     hy[0] = y;     he[0] = en && !r;
  endtask

  // Stream one full line; ev_kind 1 = 5-cycle enable gap, 2 = reset pulse,
  // 3 = threshold change, each inserted just before column ev_x.
  task automatic row(input int img, input int y, input int ev_x, input int ev_kind,
                     input int thr_new);
    for (int x = 0; x < 640; x++) begin
      if (x == ev_x) begin
        case (ev_kind)
          1: for (int g = 0; g < 5; g++) push(1'b0, x, y, img, 1'b0);
          2: push(1'b0, x, y, img, 1'b1);
          3: threshold = 8'(thr_new);
          default: ;
        endcase
      end
      push(1'b1, x, y, img, 1'b0);
    end
  endtask

  task automatic flush();
    for (int i = 0; i < 3; i++) push(1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic check_test(input int t);
    int exp_s, exp_e, exp_v;
    int act_s, act_e, act_v;
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].test == t) begin
        exp_v = int'(tbl[i].v);
        exp_e = int'(tbl[i].v && tbl[i].e);
        if (!tbl[i].v)      exp_s = 0;
        else if (Bin)       exp_s = tbl[i].e ? 255 : 0;
        else                exp_s = (tbl[i].mag > 255) ? 255 : tbl[i].mag;
        act_v = int'(cap_v[tbl[i].y % 16][tbl[i].x]);
        act_e = int'(cap_e[tbl[i].y % 16][tbl[i].x]);
        act_s = int'(cap_s[tbl[i].y % 16][tbl[i].x]);
        n_vec++;
        if (act_v != exp_v || act_e != exp_e || act_s != exp_s) begin
          n_err++;
          $display("FAIL test%0d pixel(x=%0d,y=%0d): got valid=%0d edge=%0d sobel=%0d, want valid=%0d edge=%0d sobel=%0d",
                   t, tbl[i].x, tbl[i].y, act_v, act_e, act_s, exp_v, exp_e, exp_s);
        end
      end
    end
  endtask

  initial begin
    // Flat frame, threshold 10 (and threshold 0 on rows 4-5)
    add(1, 300, 1, 0, 0, 0);   add(1, 1, 2, 0, 0, 0);   add(1, 2, 2, 1, 0, 0);
    add(1, 639, 2, 1, 0, 0);   add(1, 0, 3, 0, 0, 0);   add(1, 1, 3, 0, 0, 0);
    add(1, 5, 3, 1, 0, 0);
    add(11, 10, 4, 1, 0, 1);   add(11, 1, 4, 0, 0, 0);  add(11, 639, 5, 1, 0, 1);
    // Vertical step, threshold 128
    add(2, 318, 2, 1, 0, 0);   add(2, 319, 2, 1, 0, 0); add(2, 320, 2, 1, 800, 1);
    add(2, 321, 2, 1, 800, 1); add(2, 322, 2, 1, 0, 0); add(2, 320, 3, 1, 800, 1);
    // Horizontal step, threshold 128
    add(3, 2, 10, 1, 200, 1);  add(3, 100, 10, 1, 200, 1); add(3, 639, 11, 1, 200, 1);
    add(3, 100, 12, 1, 0, 0);  add(3, 100, 13, 1, 0, 0);
    // Horizontal step, threshold 201, switched to 200 before column 402 of row 11
    add(31, 100, 10, 1, 200, 0); add(31, 399, 11, 1, 200, 0); add(31, 400, 11, 1, 200, 1);
    add(31, 500, 11, 1, 200, 1); add(31, 100, 12, 1, 0, 0);
    // Vertical step with a 5-cycle enable gap before column 318 of row 3
    add(4, 317, 3, 1, 0, 0);   add(4, 318, 3, 1, 0, 0); add(4, 319, 3, 1, 0, 0);
    add(4, 320, 3, 1, 800, 1); add(4, 321, 3, 1, 800, 1); add(4, 322, 3, 1, 0, 0);
    // Reset at row 100 column 50
    add(5, 40, 100, 1, 0, 0);  add(5, 48, 100, 0, 0, 0); add(5, 300, 100, 0, 0, 0);
    add(5, 639, 101, 0, 0, 0); add(5, 1, 102, 0, 0, 0);  add(5, 2, 102, 1, 0, 0);
    add(5, 320, 102, 1, 800, 1); add(5, 322, 102, 1, 0, 0); add(5, 321, 103, 1, 800, 1);

    he[0] = 1'b0; he[1] = 1'b0; hx = '{0, 0}; hy = '{0, 0};
    threshold = 8'd10;
    for (int i = 0; i < 3; i++) push(1'b0, 0, 0, 0, 1'b1);
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset sobel_out", int'(sobel_out), 0);
    chk("reset edge_out", int'(edge_out), 0);
    push(1'b0, 0, 0, 0, 1'b0);

    for (int y = 0; y < 4; y++) row(0, y, -1, 0, 0);
    flush(); check_test(1);

    threshold = 8'd0;
    for (int y = 4; y < 6; y++) row(0, y, -1, 0, 0);
    flush(); check_test(11);

    threshold = 8'd128;
    for (int y = 0; y < 4; y++) row(1, y, -1, 0, 0);
    flush(); check_test(2);

    for (int y = 8; y < 14; y++) row(2, y, -1, 0, 0);
    flush(); check_test(3);

    threshold = 8'd201;
    for (int y = 8; y < 13; y++) row(2, y, (y == 11) ? 402 : -1, 3, 200);
    flush(); check_test(31);

    threshold = 8'd128;
    for (int y = 0; y < 3; y++) row(1, y, -1, 0, 0);
    gap_valid_seen = 0;
    row(1, 3, 318, 1, 0);
    flush(); check_test(4);
    chk("out_valid during enable gap", gap_valid_seen, 0);

    for (int y = 98; y < 104; y++) row(1, y, (y == 100) ? 50 : -1, 2, 0);
    flush(); check_test(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
